// File: rtl/layer_sequencer_pkg.sv
// Shared constants for the CNN layer sequencer:
// layer codes, FSM state encodings and default sizes.
package layer_sequencer_pkg;

  localparam int unsigned DATA_LEN_DEF   = 16;
  localparam int unsigned LANES_DEF      = 384;
  localparam int unsigned NUM_LAYERS_DEF = 4;
  localparam int unsigned TIMEOUT_DEF    = 4096;

  typedef enum logic [3:0] {
    L_NONE   = 4'd0,
    L_CONV1  = 4'd1,
    L_CONV2  = 4'd2,
    L_CONV3  = 4'd3,
    L_AFFINE = 4'd4
  } layer_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_WAIT = 3'd2,
    S_CAPT = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  function automatic logic [3:0] layer_code(input logic [3:0] idx);
    return idx + 4'd1;
  endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Load/valid link between the sequencer (master)
// and the CNN layer engine (slave).
interface layer_sequencer_if #(
  parameter int unsigned DATA_LEN = 16,
  parameter int unsigned LANES    = 384
);

  logic                      layer_load;
  logic [3:0]                cs_layer;
  logic [DATA_LEN*LANES-1:0] layer_d;
  logic                      layer_valid;
  logic [DATA_LEN*LANES-1:0] layer_q;

  modport master (
    output layer_load,
    output cs_layer,
    output layer_d,
    input  layer_valid,
    input  layer_q
  );

  modport slave (
    input  layer_load,
    input  cs_layer,
    input  layer_d,
    output layer_valid,
    output layer_q
  );

endinterface

// File: rtl/layer_sequencer_relu.sv
// Per-lane ReLU over a packed vector of signed lanes.
// Negative lanes (MSB set) clamp to zero.
module relu_vec #(
  parameter int unsigned DATA_LEN = 16,
  parameter int unsigned LANES    = 384
) (
  input  logic [DATA_LEN*LANES-1:0] in_i,
  output logic [DATA_LEN*LANES-1:0] out_o
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign out_o[i*DATA_LEN +: DATA_LEN] =
      in_i[i*DATA_LEN + DATA_LEN - 1] ?
      '0 : in_i[i*DATA_LEN +: DATA_LEN];
  end

endmodule

// File: rtl/layer_sequencer.sv
// Drives the layer engine through CONV1..AFFINE, chaining
// each ReLU'd result into the next layer's input.
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter int unsigned DATA_LEN   = DATA_LEN_DEF,
  parameter int unsigned LANES      = LANES_DEF,
  parameter int unsigned NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DATA_LEN*LANES-1:0] in_vec,
  output logic [DATA_LEN*LANES-1:0] result,
  output logic                      done,
  output logic                      busy,
  output logic                      error,
  layer_sequencer_if.master         eng
);

  localparam int unsigned W  = DATA_LEN * LANES;
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned IW =
    (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT - 1);
  localparam logic [IW-1:0] ILAST = IW'(NUM_LAYERS - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [W-1:0]  buf_q, buf_d;
  logic [W-1:0]  cap_q, cap_d;
  logic [W-1:0]  res_q, res_d;
  logic          err_q, err_d;
  logic [W-1:0]  relu_w;
  logic          act;

  relu_vec #(
    .DATA_LEN (DATA_LEN),
    .LANES    (LANES)
  ) u_relu (
    .in_i  (cap_q),
    .out_o (relu_w)
  );

  assign act = (state_q == S_LOAD) ||
               (state_q == S_WAIT) ||
               (state_q == S_CAPT);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    buf_d   = buf_q;
    cap_d   = cap_q;
    res_d   = res_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (start) begin
          buf_d   = in_vec;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        tmr_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tmr_d = tmr_q + TW'(1);
        // a valid on the last allowed cycle still counts
        if (eng.layer_valid) begin
          cap_d   = eng.layer_q;
          state_d = S_CAPT;
        end else if (tmr_q == TMAX) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end
      end
      S_CAPT: begin
        if (idx_q != ILAST) begin
          buf_d   = relu_w;
          idx_d   = idx_q + IW'(1);
          state_d = S_LOAD;
        end else begin
          res_d   = cap_q;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tmr_q   <= '0;
      buf_q   <= '0;
      cap_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      buf_q   <= buf_d;
      cap_q   <= cap_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign eng.layer_load = (state_q == S_LOAD);
  assign eng.cs_layer   = act ? layer_code(4'(idx_q))
                              : L_NONE;
  assign eng.layer_d    = buf_q;
  assign result         = res_q;
  assign done           = (state_q == S_DONE);
  assign busy           = act;
  assign error          = err_q;

endmodule
